// File: rtl/div_pkg.sv
// Shared definitions for the divider scheduler: word width, FSM states and
// the response record.
package div_pkg;

  localparam int WORD_W = 20;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [WORD_W-1:0] quotient;
    logic [WORD_W-1:0] remainder;
    logic              div_zero;
  } rsp_t;

endpackage

// File: rtl/div_iter_core.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so done pulses WIDTH cycles later.
module div_iter_core
  import div_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               done_r;
  logic [2*WIDTH-1:0] step_s;

  // The shifted partial remainder carries one extra bit so the trial subtract cannot overflow.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_n;
    logic             bit_q;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    if (diff[WIDTH]) begin
      rem_n = sh[WIDTH-1:0];
      bit_q = 1'b0;
    end else begin
      rem_n = diff[WIDTH-1:0];
      bit_q = 1'b1;
    end
    return {rem_n, quo[WIDTH-2:0], bit_q};
  endfunction

  // Next remainder/quotient pair: fresh operands on start, otherwise the running state.
  always_comb begin
    step_s = {(2*WIDTH){1'b0}};
    if (start) begin
      step_s = div_step({WIDTH{1'b0}}, dividend, divisor);
    end else begin
      step_s = div_step(rem_r, quo_r, divisor);
    end
  end

  // Iteration state and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= {WIDTH{1'b0}};
      quo_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        {rem_r, quo_r} <= step_s;
        cnt_r          <= CNT_W'(WIDTH - 1);
      end else if (cnt_r != {CNT_W{1'b0}}) begin
        {rem_r, quo_r} <= step_s;
        cnt_r          <= cnt_r - CNT_W'(1);
        done_r         <= (cnt_r == CNT_W'(1));
      end
    end
  end

  assign done      = done_r;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among NREQ requesters,
// with a single tagged response channel.
module div_sched
  import div_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WORD_W,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_div_zero,
  output logic                  busy
);

  state_t           state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   id_r;
  logic [WIDTH-1:0] div_r;

  logic             gnt_found_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [IDW-1:0]   scan_idx_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [NREQ-1:0]  ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_dividend_s;
  logic [WIDTH-1:0] sel_divisor_s;
  logic [WIDTH-1:0] core_divisor_s;
  logic             core_start_s;
  logic             core_done_s;
  logic [WIDTH-1:0] core_quotient_s;
  logic [WIDTH-1:0] core_remainder_s;

  // Round-robin grant: scanning downward lets the lowest offset from the pointer win.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {IDW{1'b0}};
    scan_idx_s  = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx_s  = IDW'((int'(ptr_r) + i) % NREQ);
      gnt_found_s = gnt_found_s | req_valid[scan_idx_s];
      gnt_idx_s   = req_valid[scan_idx_s] ? scan_idx_s : gnt_idx_s;
    end
  end

  // Pointer advances past the granted requester, wrapping at NREQ.
  always_comb begin
    ptr_next_s = {IDW{1'b0}};
    if (int'(gnt_idx_s) == NREQ - 1) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = gnt_idx_s + IDW'(1);
    end
  end

  // One-hot ready to the granted requester, only while idle and out of reset.
  always_comb begin
    ready_s = {NREQ{1'b0}};
    if (rst_n && (state_r == IDLE) && gnt_found_s) begin
      ready_s[gnt_idx_s] = 1'b1;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  assign req_ready      = ready_s;
  assign accept_s       = (state_r == IDLE) && gnt_found_s;
  assign sel_dividend_s = req_dividend[int'(gnt_idx_s) * WIDTH +: WIDTH];
  assign sel_divisor_s  = req_divisor[int'(gnt_idx_s) * WIDTH +: WIDTH];
  assign core_start_s   = accept_s && (sel_divisor_s != {WIDTH{1'b0}});
  assign core_divisor_s = (state_r == IDLE) ? sel_divisor_s : div_r;
  assign busy           = (state_r != IDLE);

  div_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start_s),
    .dividend  (sel_dividend_s),
    .divisor   (core_divisor_s),
    .done      (core_done_s),
    .quotient  (core_quotient_s),
    .remainder (core_remainder_s)
  );

  // Scheduler FSM with operand/ID latches and the held response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      ptr_r         <= {IDW{1'b0}};
      id_r          <= {IDW{1'b0}};
      div_r         <= {WIDTH{1'b0}};
      rsp_valid     <= 1'b0;
      rsp_id        <= {IDW{1'b0}};
      rsp_quotient  <= {WIDTH{1'b0}};
      rsp_remainder <= {WIDTH{1'b0}};
      rsp_div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ptr_r <= ptr_next_s;
            id_r  <= gnt_idx_s;
            div_r <= sel_divisor_s;
            if (sel_divisor_s == {WIDTH{1'b0}}) begin
              state_r       <= DONE;
              rsp_valid     <= 1'b1;
              rsp_id        <= gnt_idx_s;
              rsp_quotient  <= {WIDTH{1'b1}};
              rsp_remainder <= sel_dividend_s;
              rsp_div_zero  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (core_done_s) begin
            state_r       <= DONE;
            rsp_valid     <= 1'b1;
            rsp_id        <= id_r;
            rsp_quotient  <= core_quotient_s;
            rsp_remainder <= core_remainder_s;
            rsp_div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
